mips_main_controller: RTL and testbench

MIPS_MAIN_CONTROLLER -- requirements
Module: mips_main_controller

---
 rtl/mips_main_controller.sv | 176 +++++++++++++++++
 tb/tb_mips_main_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_main_controller.sv
// rtl/mips_main_controller.sv - multi-cycle MIPS main control FSM with retire counter
module mips_main_controller #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  output logic        PCWriteCond,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [15:0] instr_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  logic [3:0]  state_q, state_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        op_known;
  logic        retiring;

  // Opcode is only meaningful to the FSM in DECODE and MEMADR; elsewhere it is ignored
  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                    (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);

  // State and retire counter registers; reset wins over every transition
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state selection; stray codes 12-15 fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) state_d = S_MEMADR;
        else if (op == OP_RTYPE)            state_d = S_EXEC;
        else if (op == OP_BEQ)              state_d = S_BRANCH;
        else if (op == OP_J)                state_d = S_JUMP;
        else if (op == OP_ADDI)             state_d = S_ADDIEX;
        else                                state_d = S_FETCH;
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Retire counter advances on the edge leaving each instruction's final state
  always_comb begin
    retiring = (state_q == S_MEMWB)  || (state_q == S_MEMWR) ||
               (state_q == S_ALUWB)  || (state_q == S_BRANCH) ||
               (state_q == S_JUMP)   || (state_q == S_ADDIWB);
    instr_count_d = retiring ? (instr_count_q + 16'd1) : instr_count_q;
  end

  // Moore output decode from the registered state; anything not set stays 0
  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 2'd0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'd1;
      end
      S_DECODE: begin
        ALUSrcB    = 2'd3;
        illegal_op = !op_known;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'd2;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'd1;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_main_controller.sv
// tb/tb_mips_main_controller.sv - scoreboard bench for mips_main_controller
module tb_mips_main_controller;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg;
  logic        IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic        illegal_op;
  logic [15:0] instr_count;

  typedef struct {
    logic [5:0]  drive_op;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_count;
  int          total;
  int          passed;

  mips_main_controller dut (
    .clk(clk), .reset(reset), .op(op),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word per state, packed as
  // {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemToReg,IRWrite,RegWrite,RegDst,ALUSrcA,PCSource,ALUSrcB,ALUOp}
  function automatic logic [15:0] ctrl_of(input logic [3:0] s);
    logic pcwc, pcw, iord, mr, mw, m2r, irw, rw, rd, asa;
    logic [1:0] pcs, asb, aop;
    {pcwc, pcw, iord, mr, mw, m2r, irw, rw, rd, asa} = 10'b0;
    pcs = 2'd0; asb = 2'd0; aop = 2'd0;
    case (s)
      4'd0:  begin mr = 1; irw = 1; pcw = 1; asb = 2'd1; end
      4'd1:  begin asb = 2'd3; end
      4'd2:  begin asa = 1; asb = 2'd2; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'd2; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
      4'd9:  begin pcw = 1; pcs = 2'd2; end
      4'd10: begin asa = 1; asb = 2'd2; end
      4'd11: begin rw = 1; end
      default: ;
    endcase
    return {pcwc, pcw, iord, mr, mw, m2r, irw, rw, rd, asa, pcs, asb, aop};
  endfunction

  // Push the expected per-cycle trace of one instruction; noise scrambles op outside DECODE/MEMADR
  task automatic push_instr(input logic [5:0] opv, input bit noise, input int max_len);
    logic [3:0] path[$];
    bit known;
    exp_t e;
    known = 1'b1;
    path.push_back(4'd0);
    path.push_back(4'd1);
    case (opv)
      6'h23: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
      6'h2B: begin path.push_back(4'd2); path.push_back(4'd5); end
      6'h00: begin path.push_back(4'd6); path.push_back(4'd7); end
      6'h08: begin path.push_back(4'd10); path.push_back(4'd11); end
      6'h04: path.push_back(4'd8);
      6'h02: path.push_back(4'd9);
      default: known = 1'b0;
    endcase
    for (int i = 0; i < path.size() && i < max_len; i++) begin
      e.st       = path[i];
      e.ctrl     = ctrl_of(path[i]);
      e.ill      = (path[i] == 4'd1) && !known;
      e.cnt      = exp_count;
      e.drive_op = (noise && path[i] != 4'd1 && path[i] != 4'd2) ? 6'($urandom_range(0, 63)) : opv;
      sb.push_back(e);
    end
    if (known && path.size() <= max_len) exp_count = exp_count + 16'd1;
  endtask

  // Consume the scoreboard one cycle per entry, comparing at the falling edge
  task automatic drain(input string name);
    exp_t e;
    logic [15:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      op = e.drive_op;
      #1;
      act = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite,
             RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp};
      total++;
      if (state !== e.st) $display("FAIL %s state: got %0d expected %0d", name, state, e.st);
      else passed++;
      total++;
      if (act !== e.ctrl) $display("FAIL %s ctrl in state %0d: got %b expected %b", name, e.st, act, e.ctrl);
      else passed++;
      total++;
      if (illegal_op !== e.ill) $display("FAIL %s illegal_op in state %0d: got %b expected %b", name, e.st, illegal_op, e.ill);
      else passed++;
      total++;
      if (instr_count !== e.cnt) $display("FAIL %s instr_count in state %0d: got %0d expected %0d", name, e.st, instr_count, e.cnt);
      else passed++;
      total++;
      if ((MemRead && MemWrite) || (PCWrite && PCWriteCond))
        $display("FAIL %s exclusive strobes: MemRead=%b MemWrite=%b PCWrite=%b PCWriteCond=%b expected no overlap",
                 name, MemRead, MemWrite, PCWrite, PCWriteCond);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    op = 6'h23;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (state !== 4'd0) $display("FAIL reset state: got %0d expected 0", state);
    else passed++;
    total++;
    if (instr_count !== 16'd0) $display("FAIL reset instr_count: got %0d expected 0", instr_count);
    else passed++;
    total++;
    if (illegal_op !== 1'b0) $display("FAIL reset illegal_op: got %b expected 0", illegal_op);
    else passed++;
    total++;
    if (MemRead !== 1'b1 || IRWrite !== 1'b1 || PCWrite !== 1'b1 || ALUSrcB !== 2'd1)
      $display("FAIL reset fetch outputs: got MemRead=%b IRWrite=%b PCWrite=%b ALUSrcB=%0d expected 1,1,1,1",
               MemRead, IRWrite, PCWrite, ALUSrcB);
    else passed++;
    exp_count = 16'd0;
    reset = 1'b1;
  endtask

  task automatic test_lw();
    push_instr(6'h23, 1'b0, 99);
    drain("lw");
    total++;
    if (instr_count !== 16'd1) $display("FAIL lw retire: got %0d expected 1", instr_count);
    else passed++;
  endtask

  task automatic test_sw();
    push_instr(6'h2B, 1'b0, 99);
    drain("sw");
  endtask

  task automatic test_back_to_back();
    push_instr(6'h04, 1'b0, 99);
    push_instr(6'h02, 1'b0, 99);
    push_instr(6'h00, 1'b0, 99);
    push_instr(6'h08, 1'b0, 99);
    drain("b2b");
    total++;
    if (instr_count !== 16'd6) $display("FAIL b2b retire: got %0d expected 6", instr_count);
    else passed++;
  endtask

  task automatic test_illegal();
    push_instr(6'h3F, 1'b0, 99);
    push_instr(6'h11, 1'b0, 99);
    drain("illegal");
    total++;
    if (instr_count !== 16'd6) $display("FAIL illegal retire: got %0d expected 6", instr_count);
    else passed++;
  endtask

  task automatic test_op_ignored();
    for (int i = 0; i < 4; i++) begin
      push_instr(6'h23, 1'b1, 99);
      push_instr(6'h2B, 1'b1, 99);
      push_instr(6'h04, 1'b1, 99);
    end
    drain("op_ignored");
  endtask

  task automatic test_reset_mid();
    push_instr(6'h00, 1'b0, 2);
    drain("reset_mid");
    #1;
    total++;
    if (state !== 4'd6) $display("FAIL reset_mid pre-state: got %0d expected 6", state);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (state !== 4'd0) $display("FAIL reset_mid state: got %0d expected 0", state);
    else passed++;
    total++;
    if (instr_count !== 16'd0) $display("FAIL reset_mid instr_count: got %0d expected 0", instr_count);
    else passed++;
    total++;
    if (RegWrite !== 1'b0) $display("FAIL reset_mid RegWrite: got %b expected 0", RegWrite);
    else passed++;
    reset = 1'b1;
    exp_count = 16'd0;
    push_instr(6'h00, 1'b0, 99);
    drain("after_reset_mid");
  endtask

  task automatic test_wrap();
    force dut.instr_count_q = 16'hFFFD;
    #1;
    release dut.instr_count_q;
    exp_count = 16'hFFFD;
    repeat (3) push_instr(6'h02, 1'b0, 99);
    drain("wrap");
    total++;
    if (instr_count !== 16'd0) $display("FAIL wrap: got %0d expected 0", instr_count);
    else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    exp_count = 16'd0;
    reset = 1'b0;
    op = 6'h00;
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_op_ignored();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
